// File: rtl/train_request_agent.sv
// Track-side requester: one IDLE/WAIT/CROSS/HOLD machine per train, driving
// train_req to the crossing arbiter and flagging grant-protocol violations.
// Optional wait timeout: define TRAIN_WAIT_TIMEOUT_EN.
module train_request_agent #(
  parameter int N_TRAINS       = 4,
  parameter int CROSS_CYCLES   = 8,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int WAIT_TIMEOUT   = 32,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_TRAINS-1:0] arrive,
  input  logic [N_TRAINS-1:0] train_pass,
  output logic [N_TRAINS-1:0] train_req,
  output logic [N_TRAINS-1:0] crossing,
  output logic [N_TRAINS-1:0] done,
  output logic [N_TRAINS-1:0] timeout,
  output logic                conflict
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CROSS = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CROSS_LOAD = CNT_W'(CROSS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
`ifdef TRAIN_WAIT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_TIMEOUT - 1);
`endif

  state_e              state_q [N_TRAINS];
  logic [CNT_W-1:0]    cnt_q   [N_TRAINS];
  logic [N_TRAINS-1:0] req_q;
  logic [N_TRAINS-1:0] cross_q;
  logic [N_TRAINS-1:0] done_q;
  logic                conflict_q;
  logic                conflict_d;
  logic [N_TRAINS-1:0] grant_s;
  logic                multi_pass_s;
  logic                any_cross_s;
`ifdef TRAIN_WAIT_TIMEOUT_EN
  logic [N_TRAINS-1:0] timeout_q;
`endif

  // Lowest-index grant wins; two's-complement trick isolates it, and a
  // nonzero remainder after clearing it means more than one grant is up.
  always_comb begin
    grant_s      = train_pass & (~train_pass + N_TRAINS'(1));
    multi_pass_s = |(train_pass & (train_pass - N_TRAINS'(1)));
    any_cross_s  = |cross_q;
    conflict_d   = conflict_q | multi_pass_s
                 | (|(cross_q & ~train_pass))
                 | (|(train_pass & ~req_q));
  end

  // Per-train state machines with registered req/crossing/done/timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      cross_q    <= '0;
      done_q     <= '0;
      conflict_q <= 1'b0;
`ifdef TRAIN_WAIT_TIMEOUT_EN
      timeout_q  <= '0;
`endif
      for (int i = 0; i < N_TRAINS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= CNT_ZERO;
      end
    end else begin
      conflict_q <= conflict_d;
      for (int i = 0; i < N_TRAINS; i++) begin
        done_q[i] <= 1'b0;
`ifdef TRAIN_WAIT_TIMEOUT_EN
        timeout_q[i] <= 1'b0;
`endif
        case (state_q[i])
          ST_IDLE: begin
            if (arrive[i]) begin
              state_q[i] <= ST_WAIT;
              req_q[i]   <= 1'b1;
`ifdef TRAIN_WAIT_TIMEOUT_EN
              cnt_q[i]   <= WAIT_LOAD;
`endif
            end
          end
          ST_WAIT: begin
            // A grant on the expiry cycle still wins over the timeout.
            if (grant_s[i] && !any_cross_s) begin
              state_q[i] <= ST_CROSS;
              cross_q[i] <= 1'b1;
              cnt_q[i]   <= CROSS_LOAD;
            end
`ifdef TRAIN_WAIT_TIMEOUT_EN
            else if (cnt_q[i] == CNT_ZERO) begin
              state_q[i]   <= ST_HOLD;
              req_q[i]     <= 1'b0;
              timeout_q[i] <= 1'b1;
              cnt_q[i]     <= HOLD_LOAD;
            end else begin
              cnt_q[i] <= cnt_q[i] - CNT_ONE;
            end
`endif
          end
          ST_CROSS: begin
            if (cnt_q[i] == CNT_ZERO) begin
              state_q[i] <= ST_HOLD;
              req_q[i]   <= 1'b0;
              cross_q[i] <= 1'b0;
              done_q[i]  <= 1'b1;
              cnt_q[i]   <= HOLD_LOAD;
            end else begin
              cnt_q[i] <= cnt_q[i] - CNT_ONE;
            end
          end
          ST_HOLD: begin
            if (cnt_q[i] == CNT_ZERO) begin
              state_q[i] <= ST_IDLE;
            end else begin
              cnt_q[i] <= cnt_q[i] - CNT_ONE;
            end
          end
          default: begin
            state_q[i] <= ST_IDLE;
            req_q[i]   <= 1'b0;
            cross_q[i] <= 1'b0;
            cnt_q[i]   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign train_req = req_q;
  assign crossing  = cross_q;
  assign done      = done_q;
  assign conflict  = conflict_q;
`ifdef TRAIN_WAIT_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = '0;
`endif

endmodule
